// File: rtl/keystream_if.sv
// Bundles the key/IV inputs, the load and request strobes and the keystream outputs.
interface keystream_if #(
  parameter int KEY_W = 128,
  parameter int IV_W  = 64,
  parameter int OUT_W = 8
);
  logic [KEY_W-1:0] key_memory;
  logic [IV_W-1:0]  iv;
  logic             load_pulse;
  logic             request_hash_word_pulse;
  logic [OUT_W-1:0] hash_word;
  logic             hash_word_pulse;
  logic             ready;
  logic             keyed;

  // Key storage / consumer side: drives key, IV and strobes, receives words.
  modport master (
    output key_memory, iv, load_pulse, request_hash_word_pulse,
    input  hash_word, hash_word_pulse, ready, keyed
  );

  // Generator side.
  modport slave (
    input  key_memory, iv, load_pulse, request_hash_word_pulse,
    output hash_word, hash_word_pulse, ready, keyed
  );
endinterface

// File: rtl/keystream_generator.sv
// Keyed, IV-seeded NLFSR keystream generator with warm-up, a one-word
// prefetch buffer, a single-deep pending request and all-zero lockup guard.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | no key loaded since reset; requests ignored
// WARM  | stepping the register WARMUP times, output bits discarded
// FILL  | stepping OUT_W times, filter bits shifted into the buffer (MSB first)
// READY | buffer holds a word; a request is answered on the next cycle
module keystream_generator #(
  parameter int KEY_W  = 128,
  parameter int IV_W   = 64,
  parameter int OUT_W  = 8,
  parameter int WARMUP = 256,
  parameter int T1     = 125,
  parameter int T2     = 100,
  parameter int T3     = 98,
  parameter int T4     = 61,
  parameter int T5     = 37,
  parameter int T_OUT  = 90
) (
  input logic         clk,
  input logic         rst,
  keystream_if.slave  ks
);

  localparam int CNT_MAX = (WARMUP > OUT_W) ? WARMUP : OUT_W;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WARM  = 2'd1,
    ST_FILL  = 2'd2,
    ST_READY = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [KEY_W-1:0]  s_q, s_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]  buf_q, buf_d;
  logic              pending_q, pending_d;
  logic [OUT_W-1:0]  hash_word_q, hash_word_d;
  logic              pulse_q, pulse_d;
  logic              keyed_q, keyed_d;

  logic              load;
  logic              req;
  logic              cnt_tc;
  logic              f_bit;
  logic              z_bit;
  logic [KEY_W-1:0]  s_step;
  logic [KEY_W-1:0]  load_mix;
  logic [KEY_W-1:0]  load_val;
  logic [OUT_W-1:0]  buf_shift;
  logic              serve_now;

  assign load   = ks.load_pulse;
  assign req    = ks.request_hash_word_pulse;
  assign cnt_tc = (cnt_q == '0);

  // Step function, filter output, seeded load value and buffer shift.
  always_comb begin
    f_bit     = s_q[KEY_W-1] ^ s_q[T1] ^ s_q[T2] ^ s_q[T3] ^ (s_q[T4] & s_q[T5]);
    z_bit     = s_q[KEY_W-1] ^ s_q[T_OUT] ^ (s_q[T4] & s_q[T5]);
    s_step    = {s_q[KEY_W-2:0], f_bit};
    load_mix  = ks.key_memory ^ (KEY_W'(ks.iv) << (KEY_W - IV_W));
    // An all-zero register would never leave zero, so seed the LSB instead.
    load_val  = (load_mix == '0) ? {{(KEY_W-1){1'b0}}, 1'b1} : load_mix;
    buf_shift = OUT_W'({buf_q, z_bit});
    // The last fill step also answers a queued request or one arriving right now.
    serve_now = (state_q == ST_FILL) && cnt_tc && (pending_q || req);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a load restarts warm-up from any state.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = ST_WARM;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_WARM:  if (cnt_tc) state_d = ST_FILL;
        ST_FILL:  if (cnt_tc && !serve_now) state_d = ST_READY;
        ST_READY: if (req) state_d = ST_FILL;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Output and datapath logic: register stepping, timer, buffer, pending and delivery.
  always_comb begin
    s_d         = s_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    pending_d   = pending_q;
    hash_word_d = hash_word_q;
    pulse_d     = 1'b0;
    keyed_d     = keyed_q;
    if (load) begin
      s_d       = load_val;
      cnt_d     = CNT_W'(WARMUP - 1);
      buf_d     = '0;
      pending_d = 1'b0;
      keyed_d   = 1'b1;
    end else begin
      case (state_q)
        ST_WARM: begin
          s_d = s_step;
          if (cnt_tc) cnt_d = CNT_W'(OUT_W - 1);
          else        cnt_d = cnt_q - CNT_W'(1);
          if (req) pending_d = 1'b1;
        end
        ST_FILL: begin
          s_d   = s_step;
          buf_d = buf_shift;
          if (cnt_tc) begin
            if (serve_now) begin
              hash_word_d = buf_shift;
              pulse_d     = 1'b1;
              pending_d   = 1'b0;
              cnt_d       = CNT_W'(OUT_W - 1);
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if (req) pending_d = 1'b1;
          end
        end
        ST_READY: begin
          if (req) begin
            hash_word_d = buf_q;
            pulse_d     = 1'b1;
            cnt_d       = CNT_W'(OUT_W - 1);
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q         <= '0;
      cnt_q       <= '0;
      buf_q       <= '0;
      pending_q   <= 1'b0;
      hash_word_q <= '0;
      pulse_q     <= 1'b0;
      keyed_q     <= 1'b0;
    end else begin
      s_q         <= s_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      pending_q   <= pending_d;
      hash_word_q <= hash_word_d;
      pulse_q     <= pulse_d;
      keyed_q     <= keyed_d;
    end
  end

  assign ks.hash_word       = hash_word_q;
  assign ks.hash_word_pulse = pulse_q;
  assign ks.ready           = (state_q == ST_READY);
  assign ks.keyed           = keyed_q;

endmodule
